key_onehot_capture: RTL and testbench

//  Upstream stage of the 8-to-3 encoder. Captures 8 raw push-button/switch inputs,

---
 rtl/key_capture_pkg.sv | 17 +
 rtl/key_onehot_capture_if.sv | 15 +
 rtl/key_debounce.sv | 56 +++++
 rtl/key_onehot_capture.sv | 75 +++++++
 tb/tb_key_onehot_capture.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_capture_pkg.sv
// Shared constants and helpers for the key capture front end that feeds the 8-to-3 encoder.
package key_capture_pkg;

  localparam int N_KEYS_DEF          = 8;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  // Widest key vector lowest_onehot() accepts; callers zero-extend narrower vectors.
  localparam int KEY_VEC_MAX_W = 64;

  typedef logic [KEY_VEC_MAX_W-1:0] key_vec_t;

  // Isolates the least-significant set bit; an all-zero vector maps to zero.
  function automatic key_vec_t lowest_onehot(input key_vec_t vec);
    return vec & (~vec + key_vec_t'(1));
  endfunction

endpackage

// File: rtl/key_onehot_capture_if.sv
// Valid/ready channel carrying one one-hot key press from the capture stage to the encoder.
interface key_onehot_capture_if
  import key_capture_pkg::*;
#(
  parameter int N_KEYS = N_KEYS_DEF
);

  logic              d_valid;
  logic              d_ready;
  logic [N_KEYS-1:0] D;

  modport master (output d_valid, output D, input d_ready);
  modport slave  (input d_valid, input D, output d_ready);

endinterface

// File: rtl/key_debounce.sv
// Per-key two-flop synchroniser plus debounce filter.
// With KEY_DEBOUNCE_EN undefined, the synchronised level is passed straight through as stable.
module key_debounce
  import key_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
)(
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("key_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  logic sync1;
  logic sync2;

  // NOTE: non-blocking assignments make sync2 take the previous sync1, giving two real stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef KEY_DEBOUNCE_EN
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // The DEBOUNCE_CYCLES-th consecutive disagreeing sample commits the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt    <= '0;
      stable <= sync2;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  assign stable = sync2;
`endif

endmodule

// File: rtl/key_onehot_capture.sv
// Key press capture: debounced rising edges are queued and presented one at a time as one-hot D.
// Define KEY_DEBOUNCE_EN to insert the per-key debounce counters.
module key_onehot_capture
  import key_capture_pkg::*;
#(
  parameter int N_KEYS          = N_KEYS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_KEYS-1:0]     key_raw,
  key_onehot_capture_if.master  dout,
  output logic [N_KEYS-1:0]     pending,
  output logic                  overrun
);

  logic [N_KEYS-1:0] stable;
  logic [N_KEYS-1:0] stable_q;
  logic [N_KEYS-1:0] rise;
  logic [N_KEYS-1:0] grant;
  logic [N_KEYS-1:0] pending_next;
  logic [N_KEYS-1:0] d_q;
  logic              valid_q;
  logic              load;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (key_raw[k]),
      .stable (stable[k])
    );
  end

  // Releases are ignored; only a 0->1 change of the accepted level is a press.
  assign rise = stable & ~stable_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    load  = ~valid_q | dout.d_ready;
    grant = '0;
    if (load) begin
      grant = N_KEYS'(lowest_onehot(key_vec_t'(pending)));
    end
    // A new press on a bit being granted this cycle re-queues it: set wins over clear.
    pending_next = (pending & ~grant) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      pending  <= '0;
      overrun  <= 1'b0;
      d_q      <= '0;
      valid_q  <= 1'b0;
    end else begin
      stable_q <= stable;
      pending  <= pending_next;
      if (|(rise & pending & ~grant)) begin
        overrun <= 1'b1;
      end
      // grant is zero when nothing is queued, which also clears D and d_valid.
      if (load) begin
        d_q     <= grant;
        valid_q <= |grant;
      end
    end
  end

  assign dout.D       = d_q;
  assign dout.d_valid = valid_q;

endmodule

// File: tb/tb_key_onehot_capture.sv
// Scoreboard bench for key_onehot_capture: directed scenarios plus randomized key masks.
// Expected presses are derived from the key waveforms the bench applies; works with or without KEY_DEBOUNCE_EN.
`timescale 1ns/1ps
module tb_key_onehot_capture;

  localparam int NK  = 8;
  localparam int DEB = 4;
`ifdef KEY_DEBOUNCE_EN
  localparam int LAT = DEB + 4;
`else
  localparam int LAT = 4;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key_raw;
  logic          d_ready;
  logic [NK-1:0] pending;
  logic          overrun;

  int            ready_mode;   // 0: hold low, 1: hold high, 2: random
  int            n_vec;
  int            n_bad;
  logic [NK-1:0] exp_q[$];

  logic [NK-1:0] mask;
  logic [19:0]   pattern;
  logic          prev;
  int            rises;
  int            nb;
  int            enc;

  key_onehot_capture_if #(.N_KEYS(NK)) bus ();
  assign bus.d_ready = d_ready;

  key_onehot_capture #(
    .N_KEYS          (NK),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_raw (key_raw),
    .dout    (bus),
    .pending (pending),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 300;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
    tick(2);
  endtask

  // Consumer: d_ready changes 2 ns after each rising edge.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       d_ready = 1'b0;
      1:       d_ready = 1'b1;
      default: d_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: on the falling edge, a valid & ready pair is a transfer at the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.d_valid === 1'b1) check("d_onehot", $countones(bus.D), 1);
      else                      check("d_idle_zero", bus.D, 0);
      if (bus.d_valid === 1'b1 && d_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_press: got D=%0h, expected no transfer (t=%0t)", bus.D, $time);
        end else begin
          check("press_order", bus.D, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 500000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0; n_bad = 0;
    rst_n = 1'b0; key_raw = '0; d_ready = 1'b0; ready_mode = 0;

    // Reset state
    #1;
    check("rst_d", bus.D, 0);
    check("rst_valid", bus.d_valid, 0);
    check("rst_pending", pending, 0);
    check("rst_overrun", overrun, 0);
    tick(3);
    rst_n = 1'b1;
    tick(3);

    // Single press: latency and exactly one cycle of valid
    ready_mode = 1; tick(2);
    key_raw = 8'h08; exp_q.push_back(8'h08);
    tick(LAT - 1);
    check("lat_early_valid", bus.d_valid, 0);
    tick();
    check("lat_valid", bus.d_valid, 1);
    check("lat_d", bus.D, 8'h08);
    enc = -1;
    for (int i = 0; i < NK; i++) if (bus.D[i]) enc = i;
    check("enc_y", enc, 3);
    tick();
    check("single_cycle_valid", bus.d_valid, 0);
    key_raw = '0; tick(LAT + 2);

    // Simultaneous presses: lowest index first on consecutive cycles
    key_raw = 8'h81; exp_q.push_back(8'h01); exp_q.push_back(8'h80);
    tick(LAT);
    check("sim_first", bus.D, 8'h01);
    tick();
    check("sim_second", bus.D, 8'h80);
    tick();
    check("sim_idle", bus.d_valid, 0);
    key_raw = '0; tick(LAT + 2);

    // Bounce on key 2, then settle high
    pattern = '0; prev = 1'b0; rises = 0;
    for (int c = 0; c < 20; c++) begin
      pattern[c] = ((c / 2) % 2) == 0;
      if (pattern[c] && !prev) rises++;
      prev = pattern[c];
    end
    if (!prev) rises++;
`ifdef KEY_DEBOUNCE_EN
    rises = 1;
`endif
    for (int i = 0; i < rises; i++) exp_q.push_back(8'h04);
    for (int c = 0; c < 20; c++) begin
      key_raw[2] = pattern[c];
      tick();
    end
    key_raw[2] = 1'b1;
    tick(LAT + 2);
    drain("bounce_drain");
    check("bounce_pending", pending, 0);
    key_raw = '0; tick(LAT + 2);

    // Backpressure: D holds while a later press waits in pending
    ready_mode = 0; tick(2);
    key_raw = 8'h02; exp_q.push_back(8'h02);
    tick(LAT + 1);
    check("bp_d_first", bus.D, 8'h02);
    key_raw = 8'h22; exp_q.push_back(8'h20);
    tick(LAT + 1);
    check("bp_d_hold", bus.D, 8'h02);
    check("bp_valid_hold", bus.d_valid, 1);
    check("bp_pending", pending, 8'h20);
    ready_mode = 1;
    tick();
    check("bp_d_next", bus.D, 8'h20);
    check("bp_pending_empty", pending, 0);
    tick();
    check("bp_idle", bus.d_valid, 0);
    key_raw = '0; tick(LAT + 2);

    // Overrun: key 1 re-pressed while still pending
    ready_mode = 0; tick(2);
    check("ovr_clear_before", overrun, 0);
    key_raw = 8'h01; exp_q.push_back(8'h01);
    tick(LAT + 1);
    check("ovr_d_held", bus.D, 8'h01);
    key_raw = 8'h03; exp_q.push_back(8'h02);
    tick(LAT + 1);
    check("ovr_pending", pending, 8'h02);
    check("ovr_not_yet", overrun, 0);
    key_raw = 8'h01; tick(LAT + 2);
    key_raw = 8'h03; tick(LAT + 2);
    check("ovr_set", overrun, 1);
    check("ovr_pending_once", pending, 8'h02);
    ready_mode = 1;
    drain("ovr_drain");
    check("ovr_idle", bus.d_valid, 0);
    key_raw = '0; tick(LAT + 2);
    check("ovr_sticky", overrun, 1);

    // Asynchronous reset mid-stream, keys held through reset
    ready_mode = 0; tick(2);
    key_raw = 8'h02; exp_q.push_back(8'h02);
    tick(LAT + 1);
    key_raw = 8'h07; exp_q.push_back(8'h01); exp_q.push_back(8'h04);
    tick(LAT + 1);
    check("pre_rst_pending", pending, 8'h05);
    check("pre_rst_d", bus.D, 8'h02);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_d", bus.D, 0);
    check("mid_rst_valid", bus.d_valid, 0);
    check("mid_rst_pending", pending, 0);
    check("mid_rst_overrun", overrun, 0);
    tick(2);
    ready_mode = 1;
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h04);
    rst_n = 1'b1;
    tick(LAT + 4);
    drain("held_through_reset");
    check("post_rst_overrun", overrun, 0);
    key_raw = '0; tick(LAT + 2);

    // Randomized key masks with random consumer stalls
    ready_mode = 2;
    for (int v = 0; v < 40; v++) begin
      mask = NK'($urandom_range(1, 255));
      for (int i = 0; i < NK; i++) if (mask[i]) exp_q.push_back(NK'(1) << i);
`ifdef KEY_DEBOUNCE_EN
      nb = $urandom_range(0, 3);
      for (int b = 0; b < nb; b++) begin
        key_raw = mask;
        tick($urandom_range(1, DEB - 1));
        key_raw = '0;
        tick($urandom_range(1, DEB - 1));
      end
`endif
      key_raw = mask;
      tick(LAT + 2);
      drain("rand_drain");
      key_raw = '0;
      tick(LAT + 2);
    end
    check("rand_pending_empty", pending, 0);
    check("rand_no_overrun", overrun, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
